ntt_out_serializer: RTL and testbench

Converts the NTT core's parallel output vectors (INPUT_PER_CYCLE coefficients per beat) into a one-coefficient-per-cycle stream with valid/ready handshaking on both sides. It is the transmit-side counterpart to the serial-to-parallel input path. It sits between NTT_Top's parallel output and the host/IO side. A two-slot vector buffer lets one vector drain while the next is loaded. The block also tracks polynomial framing and generates start, last and framing-error indications.

---
 rtl/ntt_pkg.sv | 19 +
 rtl/ntt_out_serializer.sv | 110 +++++++++++
 tb/tb_ntt_out_serializer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants, index-width helpers and coefficient/vector types.
package ntt_pkg;

  localparam int DATA_WIDTH_PER_INPUT = 32;
  localparam int INPUT_PER_CYCLE      = 32;
  localparam int RING_SIZE            = 1024;

  function automatic int word_w(input int ipc);
    return (ipc <= 1) ? 1 : $clog2(ipc);
  endfunction

  function automatic int vec_w(input int vpp);
    return (vpp <= 1) ? 1 : $clog2(vpp);
  endfunction

  typedef logic [DATA_WIDTH_PER_INPUT-1:0] coeff_t;
  typedef coeff_t [INPUT_PER_CYCLE-1:0]    vec_t;

endpackage

// File: rtl/ntt_out_serializer.sv
// Parallel-to-serial converter for NTT output vectors, one coefficient per cycle.
// Two-slot buffer, valid/ready on both sides, polynomial start/last framing with a sticky error flag.
module ntt_out_serializer #(
  parameter int DATA_WIDTH_PER_INPUT = ntt_pkg::DATA_WIDTH_PER_INPUT,
  parameter int INPUT_PER_CYCLE      = ntt_pkg::INPUT_PER_CYCLE,
  parameter int RING_SIZE            = ntt_pkg::RING_SIZE
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic                                                in_start,
  input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] in_data,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [DATA_WIDTH_PER_INPUT-1:0]                     out_data,
  output logic                                                out_start,
  output logic                                                out_last,
  output logic                                                framing_err
);
  import ntt_pkg::*;

  localparam int VEC_PER_POLY = RING_SIZE / INPUT_PER_CYCLE;
  localparam int WORD_W       = word_w(INPUT_PER_CYCLE);
  localparam int VEC_W        = vec_w(VEC_PER_POLY);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(INPUT_PER_CYCLE - 1);
  localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(VEC_PER_POLY - 1);

  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] slot_data_q [2];
  logic [1:0]        slot_start_q;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [WORD_W-1:0] word_idx_q, word_idx_d;
  logic [VEC_W-1:0]  vec_idx_q, vec_idx_d;
  logic              framing_err_q, framing_err_d;

  logic             accept, emit, free, restart;
  logic [VEC_W-1:0] eff_vec;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign free      = emit && (word_idx_q == LAST_WORD);

  // A start-flagged vector restarts the polynomial count from its first word onward.
  assign restart = (word_idx_q == '0) && slot_start_q[rd_ptr_q];
  assign eff_vec = restart ? '0 : vec_idx_q;

  assign out_data    = slot_data_q[rd_ptr_q][word_idx_q];
  assign out_start   = out_valid && restart;
  assign out_last    = out_valid && (word_idx_q == LAST_WORD) && (eff_vec == LAST_VEC);
  assign framing_err = framing_err_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    word_idx_d    = word_idx_q;
    vec_idx_d     = vec_idx_q;
    framing_err_d = framing_err_q;
    if (accept) wr_ptr_d = ~wr_ptr_q;
    if (emit) begin
      vec_idx_d = eff_vec;
      if (restart && (vec_idx_q != '0)) framing_err_d = 1'b1;
      if (free) begin
        word_idx_d = '0;
        rd_ptr_d   = ~rd_ptr_q;
        vec_idx_d  = (eff_vec == LAST_VEC) ? '0 : eff_vec + 1'b1;
      end else begin
        word_idx_d = word_idx_q + 1'b1;
      end
    end
    case ({accept, free})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      word_idx_q    <= '0;
      vec_idx_q     <= '0;
      framing_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      word_idx_q    <= word_idx_d;
      vec_idx_q     <= vec_idx_d;
      framing_err_q <= framing_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_data_q[0] <= '0;
      slot_data_q[1] <= '0;
      slot_start_q   <= 2'b00;
    end else if (accept) begin
      slot_data_q[wr_ptr_q]  <= in_data;
      slot_start_q[wr_ptr_q] <= in_start;
    end
  end

endmodule

// File: tb/tb_ntt_out_serializer.sv
// Directed bench for ntt_out_serializer: scenario table plus hand-written corner sequences.
module tb_ntt_out_serializer;

  localparam int DW = 32;
  localparam int IPC = 32;
  localparam int VPP = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_start;
  logic [IPC-1:0][DW-1:0] in_data;
  logic out_valid, out_ready, out_start, out_last, framing_err;
  logic [DW-1:0] out_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  ntt_out_serializer #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC), .RING_SIZE(IPC*VPP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_start(out_start), .out_last(out_last), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_vec;
    bit start0;
    int restart;
    bit alt_ready;
    int gap;
    int rst_after;
    int exp_words;
    int exp_starts;
    int exp_lasts;
    bit exp_frm;
    bit exp_full;
  } scn_t;

  scn_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] tag(input int s, input int v, input int k);
    return 32'((s << 24) + v * IPC + k);
  endfunction

  task automatic set_vec(input int s, input int v, input bit st);
    for (int k = 0; k < IPC; k++) in_data[k] = tag(s, v, k);
    in_start = st;
  endtask

  // Called just after a rising edge; release lands well before the next one.
  task automatic pulse_rst();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    rst = 1'b0;
  endtask

  task automatic run_scn(input int s);
    scn_t t;
    int eff [64];
    bit stv [64];
    bit frmv [64];
    int nxt, c, w, v, last_acc, starts, lasts;
    bit held, frm_model, saw_full, aborted, offer;
    logic [31:0] held_d;
    t = tbl[s];
    nxt = 0;
    for (int i = 0; i < t.n_vec; i++) begin
      stv[i] = (i == 0 && t.start0) || (i == t.restart);
      frmv[i] = stv[i] && (nxt != 0);
      eff[i] = stv[i] ? 0 : nxt;
      nxt = (eff[i] + 1) % VPP;
    end
    @(posedge clk); #1;
    pulse_rst();
    c = 0; w = 0; v = 0; last_acc = 0; starts = 0; lasts = 0;
    held = 0; frm_model = 0; saw_full = 0; aborted = 0; held_d = '0;
    while (c < 5000 && w < t.n_vec * IPC && !aborted) begin
      @(posedge clk); #1;
      offer = (v < t.n_vec) && (t.gap == 0 || v == 0 || c - last_acc >= t.gap);
      in_valid = offer;
      if (offer) set_vec(s + 1, v, stv[v]);
      out_ready = t.alt_ready ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (held) chk($sformatf("s%0d stall_hold", s), out_data, held_d);
      held = 0;
      chk($sformatf("s%0d framing_err c%0d", s, c), framing_err, frm_model);
      if (out_valid && out_ready) begin
        chk($sformatf("s%0d data w%0d", s, w), out_data, tag(s + 1, w / IPC, w % IPC));
        chk($sformatf("s%0d start w%0d", s, w), out_start, (w % IPC == 0) && stv[w / IPC]);
        chk($sformatf("s%0d last w%0d", s, w), out_last, (w % IPC == IPC - 1) && eff[w / IPC] == VPP - 1);
        if (out_start) starts++;
        if (out_last) lasts++;
        if (w % IPC == 0 && frmv[w / IPC]) frm_model = 1;
        w++;
      end else if (out_valid) begin
        held = 1;
        held_d = out_data;
      end
      if (!in_ready) saw_full = 1;
      if (in_valid && in_ready) begin
        v++;
        last_acc = c;
      end
      c++;
      if (t.rst_after > 0 && w == t.rst_after) begin
        rst = 1'b1;
        #1;
        chk($sformatf("s%0d async_rst out_valid", s), out_valid, 1'b0);
        chk($sformatf("s%0d async_rst in_ready", s), in_ready, 1'b1);
        #1;
        rst = 1'b0;
        aborted = 1;
      end
    end
    in_valid = 1'b0;
    if (c >= 5000) begin
      err_cnt++;
      $display("FAIL s%0d timeout: %0d words after %0d cycles", s, w, c);
    end
    chk($sformatf("s%0d word_count", s), w, t.exp_words);
    chk($sformatf("s%0d start_count", s), starts, t.exp_starts);
    chk($sformatf("s%0d last_count", s), lasts, t.exp_lasts);
    chk($sformatf("s%0d framing_end", s), framing_err, t.exp_frm);
    chk($sformatf("s%0d saw_full", s), saw_full, t.exp_full);
  endtask

  initial begin
    //          n  st0 rstrt alt gap rst  words st last frm full
    tbl[0] = '{32, 1, -1,   0,  0,  -1, 1024, 1, 1, 0, 1};
    tbl[1] = '{32, 1, -1,   1,  0,  -1, 1024, 1, 1, 0, 1};
    tbl[2] = '{42, 1, 10,   0,  0,  -1, 1344, 2, 1, 1, 1};
    tbl[3] = '{3,  0, -1,   0,  0,  -1, 96,   0, 0, 0, 1};
    tbl[4] = '{4,  1, -1,   0,  32, -1, 128,  1, 0, 0, 0};
    tbl[5] = '{32, 1, -1,   0,  0,  40, 40,   1, 0, 0, 1};
    tbl[6] = '{32, 1, -1,   1,  0,  -1, 1024, 1, 1, 0, 1};

    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; out_ready = 1'b0; in_data = '0;
    #12 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst out_start", out_start, 1'b0);
    chk("rst out_last", out_last, 1'b0);
    chk("rst framing_err", framing_err, 1'b0);

    // Latency, stall hold, full buffer, in_ready recovery one cycle after the drain
    @(posedge clk); #1;
    out_ready = 1'b0; set_vec(15, 0, 1); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("lat out_valid", out_valid, 1'b1);
    chk("lat out_data", out_data, tag(15, 0, 0));
    chk("lat out_start", out_start, 1'b1);
    set_vec(15, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full in_ready", in_ready, 1'b0);
    chk("stall out_data", out_data, tag(15, 0, 0));
    chk("stall out_start", out_start, 1'b1);
    out_ready = 1'b1;
    repeat (31) begin @(posedge clk); #1; end
    chk("drain word31", out_data, tag(15, 0, 31));
    chk("drain in_ready low", in_ready, 1'b0);
    chk("drain out_last", out_last, 1'b0);
    @(posedge clk); #1;
    chk("drain in_ready rise", in_ready, 1'b1);
    chk("next vec word0", out_data, tag(15, 1, 0));
    chk("next vec no start", out_start, 1'b0);
    pulse_rst();

    // Accept and free in the same cycle with one vector buffered
    @(posedge clk); #1;
    out_ready = 1'b1; set_vec(16, 0, 1); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (31) begin @(posedge clk); #1; end
    chk("simul word31", out_data, tag(16, 0, 31));
    set_vec(16, 1, 0); in_valid = 1'b1;
    chk("simul in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("simul out_valid", out_valid, 1'b1);
    chk("simul no bubble", out_data, tag(16, 1, 0));
    out_ready = 1'b0; set_vec(16, 2, 0); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("simul count1 then full", in_ready, 1'b0);
    pulse_rst();

    for (int s = 0; s < 7; s++) run_scn(s);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
